alu_result_sender: RTL and testbench

Consumer-side partner of the system ALU. Captures each valid 2*WIDTH-bit ALU result and serialises it, low byte first, into WIDTH-bit words over a valid/ready handshake toward the TX FIFO writer. Holds one result in flight plus one pending result. Reports overruns when results arrive faster than the downstream path drains them.

---
 rtl/alu_result_sender.sv | 143 ++++++++++++++
 tb/tb_alu_result_sender.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_result_sender.sv
// rtl/alu_result_sender.sv - serialises 2*WIDTH-bit ALU results into WIDTH-bit words, low word first
// Optional macro ALU_TX_CHECKSUM_EN adds a third XOR checksum word to each frame.
module alu_result_sender #(
  parameter int WIDTH = 8
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               ALU_OUT_VALID,
  input  logic [2*WIDTH-1:0] ALU_OUT,
  output logic [WIDTH-1:0]   TX_DATA,
  output logic               TX_VALID,
  input  logic               TX_READY,
  output logic               BUSY,
  output logic               OVERRUN,
  output logic [7:0]         DROP_CNT
);

`ifdef ALU_TX_CHECKSUM_EN
  typedef enum logic [1:0] {IDLE, SEND_LO, SEND_HI, SEND_CK} state_t;
`else
  typedef enum logic [1:0] {IDLE, SEND_LO, SEND_HI} state_t;
`endif

  state_t             state, st_n;
  logic [2*WIDTH-1:0] hold, hold_n;
  logic [2*WIDTH-1:0] pend, pend_n;
  logic               pend_vld, pv_n;
  logic [WIDTH-1:0]   data_n;
  logic               valid_n, busy_n, ovr_n;
  logic [7:0]         drop_n;
  logic               xfer, last_x;

  // Next-state and next-output computation; the last-word transfer frees hold
  // for either the pending result or a result arriving on the same edge.
  always_comb begin
    st_n    = state;
    hold_n  = hold;
    pend_n  = pend;
    pv_n    = pend_vld;
    data_n  = TX_DATA;
    valid_n = TX_VALID;
    ovr_n   = 1'b0;
    drop_n  = DROP_CNT;
    last_x  = 1'b0;
    xfer    = TX_VALID && TX_READY;

    case (state)
      IDLE: begin
        if (ALU_OUT_VALID) begin
          hold_n  = ALU_OUT;
          data_n  = ALU_OUT[WIDTH-1:0];
          valid_n = 1'b1;
          st_n    = SEND_LO;
        end
      end
      SEND_LO: begin
        if (xfer) begin
          data_n = hold[2*WIDTH-1:WIDTH];
          st_n   = SEND_HI;
        end
      end
      SEND_HI: begin
        if (xfer) begin
`ifdef ALU_TX_CHECKSUM_EN
          data_n = hold[WIDTH-1:0] ^ hold[2*WIDTH-1:WIDTH];
          st_n   = SEND_CK;
`else
          last_x = 1'b1;
`endif
        end
      end
`ifdef ALU_TX_CHECKSUM_EN
      SEND_CK: begin
        if (xfer) last_x = 1'b1;
      end
`endif
      default: begin
        st_n    = IDLE;
        valid_n = 1'b0;
      end
    endcase

    if (last_x) begin
      if (pend_vld) begin
        hold_n = pend;
        data_n = pend[WIDTH-1:0];
        pv_n   = 1'b0;
        st_n   = SEND_LO;
      end else if (ALU_OUT_VALID) begin
        hold_n = ALU_OUT;
        data_n = ALU_OUT[WIDTH-1:0];
        st_n   = SEND_LO;
      end else begin
        valid_n = 1'b0;
        st_n    = IDLE;
      end
    end

    // Results arriving mid-frame go to the pending slot or are dropped
    if (ALU_OUT_VALID && state != IDLE) begin
      if (pend_vld) begin
        if (last_x) begin
          pend_n = ALU_OUT;
          pv_n   = 1'b1;
        end else begin
          ovr_n = 1'b1;
          if (DROP_CNT != 8'hFF) drop_n = DROP_CNT + 8'd1;
        end
      end else if (!last_x) begin
        pend_n = ALU_OUT;
        pv_n   = 1'b1;
      end
    end

    busy_n = (st_n != IDLE) || pv_n;
  end

  // State and registered outputs
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state    <= IDLE;
      hold     <= '0;
      pend     <= '0;
      pend_vld <= 1'b0;
      TX_DATA  <= '0;
      TX_VALID <= 1'b0;
      BUSY     <= 1'b0;
      OVERRUN  <= 1'b0;
      DROP_CNT <= 8'd0;
    end else begin
      state    <= st_n;
      hold     <= hold_n;
      pend     <= pend_n;
      pend_vld <= pv_n;
      TX_DATA  <= data_n;
      TX_VALID <= valid_n;
      BUSY     <= busy_n;
      OVERRUN  <= ovr_n;
      DROP_CNT <= drop_n;
    end
  end

endmodule

// File: tb/tb_alu_result_sender.sv
// tb/tb_alu_result_sender.sv - scoreboard bench for alu_result_sender
module tb_alu_result_sender;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        ALU_OUT_VALID = 1'b0;
  logic [15:0] ALU_OUT = '0;
  logic [7:0]  TX_DATA;
  logic        TX_VALID;
  logic        TX_READY = 1'b0;
  logic        BUSY;
  logic        OVERRUN;
  logic [7:0]  DROP_CNT;

`ifdef ALU_TX_CHECKSUM_EN
  localparam int NW = 3;
`else
  localparam int NW = 2;
`endif

  alu_result_sender #(.WIDTH(8)) dut (
    .CLK(CLK), .RST(RST), .ALU_OUT_VALID(ALU_OUT_VALID), .ALU_OUT(ALU_OUT),
    .TX_DATA(TX_DATA), .TX_VALID(TX_VALID), .TX_READY(TX_READY),
    .BUSY(BUSY), .OVERRUN(OVERRUN), .DROP_CNT(DROP_CNT)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  int ovr_cnt = 0;
  logic [7:0] sb[$];
  logic       prev_stall = 1'b0;
  logic [7:0] prev_d = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic push_frame(input logic [7:0] lo, input logic [7:0] hi, input logic [7:0] ck);
    sb.push_back(lo);
    sb.push_back(hi);
`ifdef ALU_TX_CHECKSUM_EN
    sb.push_back(ck);
`endif
  endtask

  // Monitor: pops expected words on transfers and checks stall stability
  always @(negedge CLK) begin
    if (!RST) begin
      prev_stall <= 1'b0;
    end else begin
      if (OVERRUN) ovr_cnt++;
      if (prev_stall) chk("stall_stable", {23'd0, TX_VALID, TX_DATA}, {23'd0, 1'b1, prev_d});
      if (TX_VALID && TX_READY) begin
        if (sb.size() == 0) chk("unexpected_word", {24'd0, TX_DATA}, 32'hFFFF_FFFF);
        else chk("word", {24'd0, TX_DATA}, {24'd0, sb.pop_front()});
      end
      prev_stall <= TX_VALID && !TX_READY;
      prev_d     <= TX_DATA;
    end
  end

  typedef struct {
    logic [15:0] res;
    logic [7:0]  lo;
    logic [7:0]  hi;
    logic [7:0]  ck;
  } vec_t;

  vec_t vecs[5];

  initial begin
    vecs[0] = '{16'h1234, 8'h34, 8'h12, 8'h26};
    vecs[1] = '{16'hABCD, 8'hCD, 8'hAB, 8'h66};
    vecs[2] = '{16'hFF00, 8'h00, 8'hFF, 8'hFF};
    vecs[3] = '{16'h0000, 8'h00, 8'h00, 8'h00};
    vecs[4] = '{16'h8001, 8'h01, 8'h80, 8'h81};

    // Reset state
    tick(); tick();
    chk("rst_tx_valid", {31'd0, TX_VALID}, 32'd0);
    chk("rst_tx_data", {24'd0, TX_DATA}, 32'd0);
    chk("rst_busy", {31'd0, BUSY}, 32'd0);
    chk("rst_overrun", {31'd0, OVERRUN}, 32'd0);
    chk("rst_drop_cnt", {24'd0, DROP_CNT}, 32'd0);
    RST = 1'b1;
    TX_READY = 1'b1;
    tick();

    // Single results, ready held high: words on consecutive cycles then idle
    for (int i = 0; i < 5; i++) begin
      ALU_OUT_VALID = 1'b1;
      ALU_OUT = vecs[i].res;
      push_frame(vecs[i].lo, vecs[i].hi, vecs[i].ck);
      tick();
      ALU_OUT_VALID = 1'b0;
      chk("first_word_latency", {23'd0, TX_VALID, TX_DATA}, {23'd0, 1'b1, vecs[i].lo});
      for (int w = 0; w < NW; w++) tick();
      chk("idle_valid", {31'd0, TX_VALID}, 32'd0);
      chk("idle_busy", {31'd0, BUSY}, 32'd0);
      chk("sb_drained", sb.size(), 32'd0);
    end

    // Backpressure in SEND_LO for 3 cycles
    TX_READY = 1'b0;
    ALU_OUT_VALID = 1'b1;
    ALU_OUT = 16'h1234;
    push_frame(8'h34, 8'h12, 8'h26);
    tick();
    ALU_OUT_VALID = 1'b0;
    tick(); tick(); tick();
    chk("stall_data", {23'd0, TX_VALID, TX_DATA}, {23'd0, 1'b1, 8'h34});
    chk("stall_busy", {31'd0, BUSY}, 32'd1);
    TX_READY = 1'b1;
    for (int w = 0; w < NW; w++) tick();
    chk("stall_drained", sb.size(), 32'd0);
    chk("stall_idle", {31'd0, TX_VALID}, 32'd0);

    // Back-to-back results: no valid gap, no overrun
    begin
      int ovr0 = ovr_cnt;
      ALU_OUT_VALID = 1'b1;
      ALU_OUT = 16'h00AA;
      push_frame(8'hAA, 8'h00, 8'hAA);
      tick();
      ALU_OUT = 16'h0055;
      push_frame(8'h55, 8'h00, 8'h55);
      tick();
      ALU_OUT_VALID = 1'b0;
      chk("b2b_busy", {31'd0, BUSY}, 32'd1);
      for (int w = 0; w < NW; w++) tick();
      chk("b2b_no_gap", {23'd0, TX_VALID, TX_DATA}, {23'd0, 1'b1, 8'h00});
      tick();
      chk("b2b_drained", sb.size(), 32'd0);
      chk("b2b_idle", {30'd0, TX_VALID, BUSY}, 32'd0);
      chk("b2b_no_overrun", ovr_cnt - ovr0, 32'd0);
    end

    // Overrun: third result dropped while stalled
    TX_READY = 1'b0;
    ALU_OUT_VALID = 1'b1;
    ALU_OUT = 16'h0101;
    push_frame(8'h01, 8'h01, 8'h00);
    tick();
    ALU_OUT = 16'h0202;
    push_frame(8'h02, 8'h02, 8'h00);
    tick();
    chk("pre_drop_overrun", {31'd0, OVERRUN}, 32'd0);
    ALU_OUT = 16'h0303;
    tick();
    ALU_OUT_VALID = 1'b0;
    chk("drop_overrun", {31'd0, OVERRUN}, 32'd1);
    chk("drop_cnt", {24'd0, DROP_CNT}, 32'd1);
    tick();
    chk("overrun_pulse_end", {31'd0, OVERRUN}, 32'd0);
    TX_READY = 1'b1;
    for (int w = 0; w < 2 * NW + 1; w++) tick();
    chk("drop_drained", sb.size(), 32'd0);
    chk("drop_idle", {30'd0, TX_VALID, BUSY}, 32'd0);
    chk("drop_cnt_hold", {24'd0, DROP_CNT}, 32'd1);

    // Asynchronous reset in SEND_HI with a pending result
    TX_READY = 1'b0;
    ALU_OUT_VALID = 1'b1;
    ALU_OUT = 16'h1111;
    push_frame(8'h11, 8'h11, 8'h00);
    tick();
    ALU_OUT = 16'h2222;
    tick();
    ALU_OUT_VALID = 1'b0;
    TX_READY = 1'b1;
    tick();
    TX_READY = 1'b0;
    chk("pre_rst_hi", {22'd0, BUSY, TX_VALID, TX_DATA}, {22'd0, 1'b1, 1'b1, 8'h11});
    #1;
    RST = 1'b0;
    #1;
    chk("async_rst_valid", {31'd0, TX_VALID}, 32'd0);
    chk("async_rst_busy", {31'd0, BUSY}, 32'd0);
    chk("async_rst_drop", {24'd0, DROP_CNT}, 32'd0);
    sb.delete();
    tick();
    RST = 1'b1;
    TX_READY = 1'b1;
    for (int w = 0; w < 6; w++) tick();
    chk("post_rst_quiet", {30'd0, TX_VALID, BUSY}, 32'd0);

`ifdef ALU_TX_CHECKSUM_EN
    ALU_OUT_VALID = 1'b1;
    ALU_OUT = 16'h1234;
    push_frame(8'h34, 8'h12, 8'h26);
    tick();
    ALU_OUT_VALID = 1'b0;
    tick(); tick();
    chk("ck_word", {23'd0, TX_VALID, TX_DATA}, {23'd0, 1'b1, 8'h26});
    tick();
    chk("ck_busy_low", {31'd0, BUSY}, 32'd0);
`endif

    chk("final_sb_empty", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
